outgoing_response_buffer: RTL and testbench
===========================================

OUTGOING_RESPONSE_BUFFER -- requirements
Module: outgoing_response_buffer

Interface
REQ-001 Parameter ID_WIDTH, default 32, meaning R id field width.
REQ-002 Parameter DATA_WIDTH, default 64, meaning R data field width.
REQ-003 Parameter RESP_WIDTH, default 2, meaning R resp field width.
REQ-004 Parameter DEPTH, default 8, meaning number of R beats stored; any value >= 2, power of two not required.
REQ-005 The block SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-006 The block SHALL have port rst, input, 1, reset that is asynchronous and active-high.
REQ-007 The block SHALL have port r_in, r_if.receiver, the R channel from the ordering unit carrying valid/ready/id/data/resp/last.
REQ-008 The block SHALL have port r_out, r_if.sender, the R channel toward the AXI master carrying valid/ready/id/data/resp/last.
REQ-009 The block SHALL have port occupancy, output, $clog2(DEPTH+1), the number of beats currently stored.
REQ-010 The block SHALL have port bursts_stored, output, $clog2(DEPTH+1), the number of stored beats with last=1.
REQ-011 The block SHALL have port out_in_burst, output, 1, which is 1 while a burst is partially delivered to the master.

Function
REQ-012 push = r_in.valid & r_in.ready; pop = r_out.valid & r_out.ready; control SHALL use bitwise operators only.
REQ-013 r_in.ready SHALL equal ~full, where full = (occupancy == DEPTH), with no dependence on r_out.ready.
REQ-014 On push, {id,data,resp,last} SHALL be written at wr_ptr, and wr_ptr SHALL advance, wrapping from DEPTH-1 to 0.
REQ-015 On pop, rd_ptr SHALL advance, wrapping from DEPTH-1 to 0.
REQ-016 r_out.id/data/resp/last SHALL be driven combinationally from the entry at rd_ptr, and SHALL be all zeros when empty.
REQ-017 There SHALL be no bypass path: a beat pushed in cycle N is presentable no earlier than cycle N+1.
REQ-018 occupancy SHALL increment on push only, decrement on pop only, and stay unchanged on push&pop.
REQ-019 bursts_stored SHALL increment on push with r_in.last=1, decrement on pop with head last=1, and stay unchanged when both occur or neither occurs.
REQ-020 The output FSM SHALL have states OUT_IDLE and OUT_BURST, and out_in_burst SHALL equal (state == OUT_BURST).
REQ-021 The FSM SHALL go OUT_IDLE->OUT_BURST on pop with head last=0, go OUT_BURST->OUT_IDLE on pop with head last=1, and hold otherwise; a single-beat burst stays in OUT_IDLE.
REQ-022 In OUT_BURST, r_out.valid SHALL equal ~empty.
REQ-023 Once asserted, r_out.valid and the head fields SHALL stay stable until pop; a stored entry can never be withdrawn.
REQ-024 Beats SHALL leave in arrival order, with no reordering or interleaving by id.

Reset
REQ-025 While rst=1, wr_ptr, rd_ptr, occupancy and bursts_stored SHALL be 0, state SHALL be OUT_IDLE, r_out.valid SHALL be 0, r_in.ready SHALL be 1, and r_out fields SHALL be 0.
REQ-026 Reset asserted mid-burst SHALL discard all stored beats without completing them, with no output glitch beyond the reset values.
REQ-027 Storage array contents SHALL NOT require reset.

Configuration
REQ-028 The macro R_STORE_FWD_EN SHALL select store-and-forward start gating in OUT_IDLE.
REQ-029 With R_STORE_FWD_EN defined, r_out.valid in OUT_IDLE SHALL be ~empty & ((bursts_stored != 0) | full), where full overrides to prevent deadlock on bursts longer than DEPTH.
REQ-030 With R_STORE_FWD_EN undefined, r_out.valid in OUT_IDLE SHALL be ~empty, i.e. cut-through.
REQ-031 All other behaviour, including ports and the FSM, SHALL be identical in both builds.

Verification (DEPTH=4)
REQ-032 Scenario, reset: push id=3,data=0xAA,last=1 and hold r_out.ready=1 -> r_out.valid=1 the next cycle with data 0xAA; pop; occupancy returns to 0.
REQ-033 Scenario, full: 4 pushes with r_out.ready=0 -> r_in.ready=0 and occupancy=4; a 5th r_in.valid is not accepted; one pop -> r_in.ready=1 the next cycle.
REQ-034 Scenario, wrap: 10 beats data 0..9 with random ready on both sides -> r_out sequence is 0..9 in order, and both pointers wrap at least twice.
REQ-035 Scenario, R_STORE_FWD_EN build: push 2 beats last=0 then pause -> r_out.valid stays 0; push last=1 -> valid=1 the next cycle; 3 pops follow, and out_in_burst goes 0,1,1,0.
REQ-036 Scenario, R_STORE_FWD_EN build: 4 beats last=0 fill the FIFO -> valid=1 via the full override; the burst drains and completes with a 6-beat total.
REQ-037 Scenario, reset mid-burst: after pop of 1 of 3 beats, pulse rst -> occupancy=0, bursts_stored=0, out_in_burst=0, r_out.valid=0 immediately.

Source files
------------

// File: rtl/outgoing_response_buffer_if.sv
// rtl/outgoing_response_buffer_if.sv - AXI R channel bundle (valid/ready/id/data/resp/last)
interface r_if #(
  parameter int ID_WIDTH   = 32,
  parameter int DATA_WIDTH = 64,
  parameter int RESP_WIDTH = 2
);
  logic                  valid;
  logic                  ready;
  logic [ID_WIDTH-1:0]   id;
  logic [DATA_WIDTH-1:0] data;
  logic [RESP_WIDTH-1:0] resp;
  logic                  last;

  modport receiver (input valid, input id, input data, input resp, input last, output ready);
  modport sender   (output valid, output id, output data, output resp, output last, input ready);
endinterface

// File: rtl/outgoing_response_buffer.sv
// rtl/outgoing_response_buffer.sv - R beat FIFO toward the AXI master; R_STORE_FWD_EN enables store-and-forward start gating
module outgoing_response_buffer #(
  parameter int ID_WIDTH   = 32,
  parameter int DATA_WIDTH = 64,
  parameter int RESP_WIDTH = 2,
  parameter int DEPTH      = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  r_if.receiver                      r_in,
  r_if.sender                        r_out,
  output logic [$clog2(DEPTH+1)-1:0] occupancy,
  output logic [$clog2(DEPTH+1)-1:0] bursts_stored,
  output logic                       out_in_burst
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH+1);
  localparam logic [PTR_W-1:0] LAST_IDX = PTR_W'(DEPTH-1);
  localparam logic [CNT_W-1:0] DEPTH_C  = CNT_W'(DEPTH);

  typedef enum logic {OUT_IDLE, OUT_BURST} out_state_t;

  // Storage array; contents are only meaningful between wr_ptr and rd_ptr, so no reset
  logic [ID_WIDTH-1:0]   r_mem_id   [DEPTH];
  logic [DATA_WIDTH-1:0] r_mem_data [DEPTH];
  logic [RESP_WIDTH-1:0] r_mem_resp [DEPTH];
  logic                  r_mem_last [DEPTH];

  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_occ;
  logic [CNT_W-1:0] r_bursts;
  out_state_t       r_state;

  logic w_empty;
  logic w_full;
  logic w_ready;
  logic w_valid;
  logic w_push;
  logic w_pop;
  logic w_push_last;
  logic w_pop_last;

  logic [ID_WIDTH-1:0]   w_head_id;
  logic [DATA_WIDTH-1:0] w_head_data;
  logic [RESP_WIDTH-1:0] w_head_resp;
  logic                  w_head_last;

  function automatic logic [PTR_W-1:0] f_next_ptr(input logic [PTR_W-1:0] p);
    return (p == LAST_IDX) ? '0 : p + 1'b1;
  endfunction

  assign w_empty = (r_occ == '0);
  assign w_full  = (r_occ == DEPTH_C);

  // Acceptance depends only on our own fill level, never on the downstream ready
  assign w_ready = ~w_full;

  assign w_push      = r_in.valid & w_ready;
  assign w_pop       = w_valid & r_out.ready;
  assign w_push_last = w_push & r_in.last;
  assign w_pop_last  = w_pop & w_head_last;

  // Head fields read straight from storage, forced to zero when nothing is held
  assign w_head_id   = w_empty ? '0   : r_mem_id[r_rd_ptr];
  assign w_head_data = w_empty ? '0   : r_mem_data[r_rd_ptr];
  assign w_head_resp = w_empty ? '0   : r_mem_resp[r_rd_ptr];
  assign w_head_last = w_empty ? 1'b0 : r_mem_last[r_rd_ptr];

  // Output valid: mid-burst always streams; a new burst may be held back until it is complete
  always_comb begin
    w_valid = 1'b0;
    if (r_state == OUT_BURST) begin
      w_valid = ~w_empty;
    end else begin
`ifdef R_STORE_FWD_EN
      // full overrides so a burst longer than the FIFO cannot deadlock
      w_valid = ~w_empty & ((r_bursts != '0) | w_full);
`else
      w_valid = ~w_empty;
`endif
    end
  end

  // Write incoming beats into the slot at wr_ptr
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem_id[r_wr_ptr]   <= r_in.id;
      r_mem_data[r_wr_ptr] <= r_in.data;
      r_mem_resp[r_wr_ptr] <= r_in.resp;
      r_mem_last[r_wr_ptr] <= r_in.last;
    end
  end

  // Pointer and counter bookkeeping; simultaneous push and pop cancel out
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_occ    <= '0;
      r_bursts <= '0;
    end else begin
      if (w_push) r_wr_ptr <= f_next_ptr(r_wr_ptr);
      if (w_pop)  r_rd_ptr <= f_next_ptr(r_rd_ptr);
      case ({w_push, w_pop})
        2'b10:   r_occ <= r_occ + 1'b1;
        2'b01:   r_occ <= r_occ - 1'b1;
        default: r_occ <= r_occ;
      endcase
      case ({w_push_last, w_pop_last})
        2'b10:   r_bursts <= r_bursts + 1'b1;
        2'b01:   r_bursts <= r_bursts - 1'b1;
        default: r_bursts <= r_bursts;
      endcase
    end
  end

  // Output burst tracker: leaves IDLE on a non-last pop, returns on the last pop
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= OUT_IDLE;
    end else if (w_pop) begin
      case (r_state)
        OUT_IDLE:  if (~w_head_last) r_state <= OUT_BURST;
        OUT_BURST: if (w_head_last)  r_state <= OUT_IDLE;
        default:   r_state <= OUT_IDLE;
      endcase
    end
  end

  assign r_in.ready    = w_ready;
  assign r_out.valid   = w_valid;
  assign r_out.id      = w_head_id;
  assign r_out.data    = w_head_data;
  assign r_out.resp    = w_head_resp;
  assign r_out.last    = w_head_last;
  assign occupancy     = r_occ;
  assign bursts_stored = r_bursts;
  assign out_in_burst  = (r_state == OUT_BURST);

endmodule

// File: tb/tb_outgoing_response_buffer.sv
// tb/tb_outgoing_response_buffer.sv - directed checks for outgoing_response_buffer at DEPTH=4
module tb_outgoing_response_buffer;
  localparam int IDW = 8;
  localparam int DW  = 16;
  localparam int RW  = 2;
  localparam int DEP = 4;
  localparam int CW  = $clog2(DEP+1);

  logic          clk;
  logic          rst;
  logic [CW-1:0] occupancy;
  logic [CW-1:0] bursts_stored;
  logic          out_in_burst;

  r_if #(.ID_WIDTH(IDW), .DATA_WIDTH(DW), .RESP_WIDTH(RW)) u_in ();
  r_if #(.ID_WIDTH(IDW), .DATA_WIDTH(DW), .RESP_WIDTH(RW)) u_out ();

  outgoing_response_buffer #(
    .ID_WIDTH(IDW), .DATA_WIDTH(DW), .RESP_WIDTH(RW), .DEPTH(DEP)
  ) dut (
    .clk(clk),
    .rst(rst),
    .r_in(u_in),
    .r_out(u_out),
    .occupancy(occupancy),
    .bursts_stored(bursts_stored),
    .out_in_burst(out_in_burst)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_mis = 0;
  int n_pops = 0;
  logic [63:0] exp_q[$];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_mis++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_in(input logic v, input int d, input logic l);
    u_in.valid = v;
    u_in.id    = IDW'(d);
    u_in.data  = DW'(d);
    u_in.resp  = '0;
    u_in.last  = l;
  endtask

  // mode: 0 never, 1 always, 2 random; stops when all pushed and (if popping) the model queue is empty
  task automatic traffic(input int n, input int base, input logic [15:0] lmask,
                         input int in_mode, input int out_mode);
    int snd = 0;
    int cyc = 0;
    logic pu, po;
    logic [DW-1:0] od;
    while (((snd < n) || ((out_mode != 0) && (exp_q.size() != 0))) && (cyc < 500)) begin
      drive_in((snd < n) && ((in_mode == 1) || ((in_mode == 2) && ($urandom_range(0, 1) == 1))),
               base + snd, lmask[snd]);
      u_out.ready = (out_mode == 1) || ((out_mode == 2) && ($urandom_range(0, 1) == 1));
      @(negedge clk);
      pu = u_in.valid & u_in.ready;
      po = u_out.valid & u_out.ready;
      od = u_out.data;
      step();
      if (pu) begin
        exp_q.push_back(64'(DW'(base + snd)));
        snd++;
      end
      if (po) begin
        n_pops++;
        if (exp_q.size() == 0) check("spurious_pop", 64'(od), 64'hdead);
        else check("order", 64'(od), exp_q.pop_front());
      end
      cyc++;
    end
    u_in.valid  = 1'b0;
    u_out.ready = 1'b0;
    check("traffic_bound", 64'(cyc < 500), 64'd1);
  endtask

  initial begin
    rst = 1'b1;
    drive_in(1'b0, 0, 1'b0);
    u_out.ready = 1'b0;

    // reset values
    @(negedge clk);
    check("rst_occ", 64'(occupancy), 64'd0);
    check("rst_bursts", 64'(bursts_stored), 64'd0);
    check("rst_in_burst", 64'(out_in_burst), 64'd0);
    check("rst_valid", 64'(u_out.valid), 64'd0);
    check("rst_ready", 64'(u_in.ready), 64'd1);
    check("rst_data", 64'(u_out.data), 64'd0);
    step();
    rst = 1'b0;

    // single beat, no bypass, then popped
    drive_in(1'b1, 8'h03, 1'b1);
    u_in.data   = 16'h00AA;
    u_out.ready = 1'b1;
    #1;
    check("nobypass_valid", 64'(u_out.valid), 64'd0);
    step();
    u_in.valid = 1'b0;
    check("s1_valid", 64'(u_out.valid), 64'd1);
    check("s1_data", 64'(u_out.data), 64'h00AA);
    check("s1_id", 64'(u_out.id), 64'd3);
    check("s1_occ", 64'(occupancy), 64'd1);
    check("s1_bursts", 64'(bursts_stored), 64'd1);
    step();
    u_out.ready = 1'b0;
    check("s1_occ_after", 64'(occupancy), 64'd0);
    check("s1_valid_after", 64'(u_out.valid), 64'd0);
    check("s1_bursts_after", 64'(bursts_stored), 64'd0);

    // full: four beats fill, fifth refused until a pop frees a slot
    for (int k = 0; k < 4; k++) begin
      drive_in(1'b1, 'h10 + k, 1'b0);
      step();
    end
    drive_in(1'b1, 'h14, 1'b1);
    check("full_ready", 64'(u_in.ready), 64'd0);
    check("full_occ", 64'(occupancy), 64'd4);
    check("full_valid", 64'(u_out.valid), 64'd1);
    check("full_head", 64'(u_out.data), 64'h10);
    step();
    check("full_5th_refused", 64'(occupancy), 64'd4);
    u_out.ready = 1'b1;
    step();
    u_out.ready = 1'b0;
    check("full_pop_occ", 64'(occupancy), 64'd3);
    check("full_pop_ready", 64'(u_in.ready), 64'd1);
    check("full_pop_burst", 64'(out_in_burst), 64'd1);
    step();
    u_in.valid = 1'b0;
    check("full_5th_taken", 64'(occupancy), 64'd4);
    u_out.ready = 1'b1;
    for (int d = 'h11; d <= 'h14; d++) begin
      check("full_drain_valid", 64'(u_out.valid), 64'd1);
      check("full_drain_data", 64'(u_out.data), 64'(d));
      step();
    end
    u_out.ready = 1'b0;
    check("full_end_occ", 64'(occupancy), 64'd0);
    check("full_end_burst", 64'(out_in_burst), 64'd0);
    check("full_end_bursts", 64'(bursts_stored), 64'd0);

    // start gating: two non-last beats, pause, then the last beat
    drive_in(1'b1, 'h30, 1'b0);
    step();
`ifdef R_STORE_FWD_EN
    check("sf_gated_1", 64'(u_out.valid), 64'd0);
`else
    check("ct_valid_1", 64'(u_out.valid), 64'd1);
`endif
    drive_in(1'b1, 'h31, 1'b0);
    step();
    u_in.valid = 1'b0;
    step();
    step();
`ifdef R_STORE_FWD_EN
    check("sf_gated_pause", 64'(u_out.valid), 64'd0);
`else
    check("ct_valid_pause", 64'(u_out.valid), 64'd1);
`endif
    check("gate_occ", 64'(occupancy), 64'd2);
    drive_in(1'b1, 'h32, 1'b1);
    step();
    u_in.valid = 1'b0;
    check("gate_valid_last", 64'(u_out.valid), 64'd1);
    check("gate_bursts", 64'(bursts_stored), 64'd1);
    u_out.ready = 1'b1;
    check("gate_ib0", 64'(out_in_burst), 64'd0);
    check("gate_d0", 64'(u_out.data), 64'h30);
    step();
    check("gate_ib1", 64'(out_in_burst), 64'd1);
    check("gate_d1", 64'(u_out.data), 64'h31);
    step();
    check("gate_ib2", 64'(out_in_burst), 64'd1);
    check("gate_d2", 64'(u_out.data), 64'h32);
    step();
    u_out.ready = 1'b0;
    check("gate_ib3", 64'(out_in_burst), 64'd0);
    check("gate_occ_end", 64'(occupancy), 64'd0);

    // long burst: fill with non-last beats, full override starts it, 6 beats total
    n_pops = 0;
    traffic(4, 'h40, 16'h0000, 1, 0);
    check("long_valid_full", 64'(u_out.valid), 64'd1);
    check("long_occ", 64'(occupancy), 64'd4);
    traffic(2, 'h44, 16'h0002, 1, 1);
    check("long_pops", 64'(n_pops), 64'd6);
    check("long_ib_end", 64'(out_in_burst), 64'd0);
    check("long_occ_end", 64'(occupancy), 64'd0);

    // wrap: ten beats with random ready on both sides
    n_pops = 0;
    traffic(10, 0, 16'h0210, 2, 2);
    check("wrap_pops", 64'(n_pops), 64'd10);
    check("wrap_occ_end", 64'(occupancy), 64'd0);
    check("wrap_bursts_end", 64'(bursts_stored), 64'd0);

    // reset mid-burst after one of three beats has left
    traffic(3, 'h50, 16'h0004, 1, 0);
    u_out.ready = 1'b1;
    step();
    u_out.ready = 1'b0;
    check("mid_ib", 64'(out_in_burst), 64'd1);
    check("mid_occ", 64'(occupancy), 64'd2);
    rst = 1'b1;
    #1;
    check("mid_rst_occ", 64'(occupancy), 64'd0);
    check("mid_rst_bursts", 64'(bursts_stored), 64'd0);
    check("mid_rst_ib", 64'(out_in_burst), 64'd0);
    check("mid_rst_valid", 64'(u_out.valid), 64'd0);
    check("mid_rst_data", 64'(u_out.data), 64'd0);
    check("mid_rst_ready", 64'(u_in.ready), 64'd1);
    step();
    rst = 1'b0;
    exp_q.delete();
    step();
    check("post_rst_valid", 64'(u_out.valid), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end
endmodule
